serial_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single serial bus between N_MASTERS requesters. It grants exactly one requester at a time and holds the grant for one complete byte transaction, from the start handshake to the transmit-done pulse. It inserts one turnaround cycle between owners and recovers the bus through watchdog timeouts if an owner stalls. It sits between the master request logic and the bus mux/serializer, and drives the mux select.

---
 rtl/serial_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// Round-robin owner arbitration for the shared serial bus. Each grant covers one byte
// transaction. Owners are separated by a turnaround cycle, and watchdogs reclaim the bus from stalled owners.
module serial_bus_arbiter #(
  parameter int N_MASTERS     = 4,
  parameter int START_TIMEOUT = 16,
  parameter int TX_TIMEOUT    = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_MASTERS-1:0]         req_i,
  input  logic                         tx_start_i,
  input  logic                         tx_done_i,
  output logic [N_MASTERS-1:0]         grant_o,
  output logic [$clog2(N_MASTERS)-1:0] grant_id_o,
  output logic                         bus_idle_o,
  output logic                         timeout_err_o,
  output logic [$clog2(N_MASTERS)-1:0] err_id_o
);

  localparam int IDW = $clog2(N_MASTERS);
  localparam int TW  = $clog2(TX_TIMEOUT + 1);

  localparam logic [TW-1:0]        START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0]        TX_LAST    = TW'(TX_TIMEOUT - 1);
  localparam logic [IDW-1:0]       LAST_ID    = IDW'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] ONE_HOT0   = N_MASTERS'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANTED,
    ST_BUSY,
    ST_RELEASE
  } state_e;

  state_e               state_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [IDW-1:0]       grant_id_q;
  logic                 bus_idle_q;
  logic                 timeout_err_q;
  logic [IDW-1:0]       err_id_q;
  logic [TW-1:0]        timer_q;

  logic                 pick_vld_d;
  logic [IDW-1:0]       pick_id_d;
  logic [N_MASTERS-1:0] pick_oh_d;
  logic [TW-1:0]        timer_d;

  // Position of master (base + offs) on the ring, wrapping at N_MASTERS rather than at 2**IDW.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int offs);
    return IDW'((int'(base) + offs) % N_MASTERS);
  endfunction

  // Walk the ring from the farthest candidate back to the nearest, so the nearest
  // requester after the last owner is the value that survives.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pick_vld_d = 1'b0;
    pick_id_d  = grant_id_q;
    for (int i = N_MASTERS; i >= 1; i--) begin
      if (req_i[wrap_idx(grant_id_q, i)]) begin
        pick_vld_d = 1'b1;
        pick_id_d  = wrap_idx(grant_id_q, i);
      end
    end
  end

  assign pick_oh_d = ONE_HOT0 << pick_id_d;
  assign timer_d   = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so that every register samples pre-edge values.
    if (rst_i) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_id_q    <= LAST_ID;
      bus_idle_q    <= 1'b1;
      timeout_err_q <= 1'b0;
      err_id_q      <= '0;
      timer_q       <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld_d) begin
            state_q    <= ST_GRANTED;
            grant_q    <= pick_oh_d;
            grant_id_q <= pick_id_d;
            bus_idle_q <= 1'b0;
            timer_q    <= '0;
          end
        end

        // A start handshake beats both an owner withdrawal and the watchdog.
        ST_GRANTED: begin
          if (tx_start_i) begin
            state_q <= ST_BUSY;
            timer_q <= '0;
          end else if (!req_i[grant_id_q]) begin
            state_q <= ST_RELEASE;
            grant_q <= '0;
            timer_q <= '0;
          end else if (timer_q == START_LAST) begin
            state_q       <= ST_RELEASE;
            grant_q       <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b1;
            err_id_q      <= grant_id_q;
          end else begin
            timer_q <= timer_d;
          end
        end

        // Requests are ignored while busy. Only done or the watchdog ends the byte.
        ST_BUSY: begin
          if (tx_done_i) begin
            state_q <= ST_RELEASE;
            grant_q <= '0;
            timer_q <= '0;
          end else if (timer_q == TX_LAST) begin
            state_q       <= ST_RELEASE;
            grant_q       <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b1;
            err_id_q      <= grant_id_q;
          end else begin
            timer_q <= timer_d;
          end
        end

        ST_RELEASE: begin
          state_q    <= ST_IDLE;
          bus_idle_q <= 1'b1;
          timer_q    <= '0;
        end

        default: begin
          state_q    <= ST_IDLE;
          grant_q    <= '0;
          bus_idle_q <= 1'b1;
          timer_q    <= '0;
        end
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = grant_id_q;
  assign bus_idle_o    = bus_idle_q;
  assign timeout_err_o = timeout_err_q;
  assign err_id_o      = err_id_q;

  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(grant_q));
  a_grant_owner   : assert property (@(posedge clk_i) disable iff (rst_i)
                      (grant_q != '0) == (state_q == ST_GRANTED || state_q == ST_BUSY));
  a_idle_no_grant : assert property (@(posedge clk_i) disable iff (rst_i)
                      bus_idle_q |-> (grant_q == '0));

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter. A timestamp-based ownership model is checked every cycle,
// and directed scenarios are pinned with literal values.
module tb_serial_bus_arbiter;

  localparam int N  = 4;
  localparam int ST = 16;
  localparam int TT = 64;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          tx_start = 1'b0;
  logic          tx_done = 1'b0;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          bus_idle;
  logic          timeout_err;
  logic [IW-1:0] err_id;

  serial_bus_arbiter #(
    .N_MASTERS    (N),
    .START_TIMEOUT(ST),
    .TX_TIMEOUT   (TT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .tx_start_i   (tx_start),
    .tx_done_i    (tx_done),
    .grant_o      (grant),
    .grant_id_o   (grant_id),
    .bus_idle_o   (bus_idle),
    .timeout_err_o(timeout_err),
    .err_id_o     (err_id)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. It tracks the owner and the edge numbers at which that owner was granted,
  // started, or released. Each deadline is a difference of edge numbers.
  int m_cyc   = 0;
  int m_owner = -1;
  int m_last  = N - 1;
  int m_started = 0;
  int m_gedge = 0;
  int m_t0    = 0;
  int m_rel   = -1000;
  int m_terr  = 0;
  int m_errid = 0;
  bit m_valid = 1'b0;

  task automatic release_bus(input int timed_out);
    if (timed_out != 0) begin
      m_terr  = 1;
      m_errid = m_owner;
    end
    m_owner = -1;
    m_rel   = m_cyc;
  endtask

  task automatic model_step();
    m_cyc++;
    if (rst) begin
      m_valid = 1'b1;
      m_owner = -1;
      m_last  = N - 1;
      m_started = 0;
      m_rel   = -1000;
      m_terr  = 0;
      m_errid = 0;
      return;
    end
    m_terr = 0;
    if (m_owner >= 0) begin
      if (m_started == 0) begin
        if (tx_start) begin
          m_started = 1;
          m_t0 = m_cyc;
        end else if (!req[m_owner]) release_bus(0);
        else if (m_cyc - m_gedge == ST) release_bus(1);
      end else begin
        if (tx_done) release_bus(0);
        else if (m_cyc - m_t0 == TT) release_bus(1);
      end
    end else if (m_cyc - m_rel >= 2) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_last  = c;
          m_started = 0;
          m_gedge = m_cyc;
          m_t0    = m_cyc;
        end
      end
    end
  endtask

  // Compare process: the model advances on each edge, and the DUT is compared to it 1 time unit later.
  always begin
    logic [N-1:0] eg;
    @(posedge clk);
    #1;
    model_step();
    if (m_valid) begin
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      check("cyc_grant",       32'(grant),       32'(eg));
      check("cyc_grant_id",    32'(grant_id),    32'(m_last));
      check("cyc_bus_idle",    32'(bus_idle),    32'((m_owner < 0) && (m_cyc - m_rel >= 1)));
      check("cyc_timeout_err", 32'(timeout_err), 32'(m_terr));
      check("cyc_err_id",      32'(err_id),      32'(m_errid));
      check("cyc_onehot0",     32'($onehot0(grant)), 32'd1);
    end
  end

  // One clock edge. Returns at the following negedge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int plan_edge = -1;
  int start_dly = 0;
  int done_dly  = 0;

  initial begin
    int w;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] one = 4'b0001;

    // Scenario 1: reset values, then a single complete transaction.
    do_reset();
    check("rst_grant",    32'(grant),       32'h0);
    check("rst_grant_id", 32'(grant_id),    32'h3);
    check("rst_bus_idle", 32'(bus_idle),    32'h1);
    check("rst_terr",     32'(timeout_err), 32'h0);
    check("rst_err_id",   32'(err_id),      32'h0);
    req = 4'b0001;
    step();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy_flag", 32'(bus_idle), 32'h0);
    step();
    tx_start = 1'b1; step(); tx_start = 1'b0;
    repeat (8) step();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    req = '0;
    check("t1_release_grant", 32'(grant), 32'h0);
    check("t1_release_idle",  32'(bus_idle), 32'h0);
    step();
    check("t1_idle", 32'(bus_idle), 32'h1);

    // Scenario 2: all four masters request continuously, so grants rotate with a 2-cycle gap.
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      w = 0;
      while (grant == '0 && w < 8) begin
        step();
        w++;
      end
      if (t > 0) check("t2_gap", 32'(w), 32'd2);
      check("t2_grant",    32'(grant),    32'(one << order[t]));
      check("t2_grant_id", 32'(grant_id), 32'(order[t]));
      tx_start = 1'b1; step(); tx_start = 1'b0;
      repeat (8) step();
      tx_done = 1'b1; step(); tx_done = 1'b0;
      check("t2_release", 32'(grant), 32'h0);
    end
    req = '0;
    step(); step();

    // Scenario 3: the start watchdog fires, then the master is re-granted.
    do_reset();
    req = 4'b0100;
    step();
    w = 0;
    while (grant == 4'b0100 && w < 40) begin
      step();
      w++;
    end
    check("t3_hold_cycles", 32'(w), 32'd16);
    check("t3_terr",   32'(timeout_err), 32'h1);
    check("t3_err_id", 32'(err_id),      32'h2);
    check("t3_grant0", 32'(grant),       32'h0);
    step();
    check("t3_terr_pulse", 32'(timeout_err), 32'h0);
    step();
    check("t3_regrant", 32'(grant), 32'h4);
    req = '0;
    step();
    check("t3_withdraw_no_err", 32'(timeout_err), 32'h0);
    step();

    // Scenario 4: the transfer watchdog fires on master 1, then pending master 3 is served.
    do_reset();
    req = 4'b0010;
    step();
    check("t4_grant1", 32'(grant), 32'h2);
    tx_start = 1'b1; req = 4'b1010; step(); tx_start = 1'b0;
    w = 0;
    while (grant == 4'b0010 && w < 100) begin
      step();
      w++;
    end
    check("t4_busy_cycles", 32'(w), 32'd64);
    check("t4_terr",   32'(timeout_err), 32'h1);
    check("t4_err_id", 32'(err_id),      32'h1);
    req = 4'b1000;
    step(); step();
    check("t4_grant3",    32'(grant),    32'h8);
    check("t4_grant_id3", 32'(grant_id), 32'h3);
    req = '0;
    step(); step();

    // Scenario 5: the owner withdraws before start, and a stray tx_done arrives while idle.
    do_reset();
    req = 4'b0010;
    step();
    check("t5_grant", 32'(grant), 32'h2);
    req = '0;
    step();
    check("t5_release_grant", 32'(grant),       32'h0);
    check("t5_release_idle",  32'(bus_idle),    32'h0);
    check("t5_no_err",        32'(timeout_err), 32'h0);
    tx_done = 1'b1; step(); tx_done = 1'b0;
    check("t5_idle", 32'(bus_idle), 32'h1);
    step();
    check("t5_stray_done", 32'(grant), 32'h0);

    // Scenario 6: reset arrives in the middle of a transfer.
    do_reset();
    req = 4'b1000;
    step();
    check("t6_grant3", 32'(grant), 32'h8);
    tx_start = 1'b1; step(); tx_start = 1'b0;
    repeat (3) step();
    do_reset();
    check("t6_rst_grant",    32'(grant),       32'h0);
    check("t6_rst_idle",     32'(bus_idle),    32'h1);
    check("t6_rst_grant_id", 32'(grant_id),    32'h3);
    check("t6_rst_terr",     32'(timeout_err), 32'h0);
    req = 4'b1001;
    step();
    check("t6_first0", 32'(grant), 32'h1);
    req = '0;
    step(); step();

    // Scenario 7: start and withdrawal arrive together (start wins), then done lands on the timeout edge (done wins).
    do_reset();
    req = 4'b0001;
    step();
    tx_start = 1'b1; req = '0; step(); tx_start = 1'b0;
    check("t7_start_wins", 32'(grant), 32'h1);
    repeat (63) step();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    check("t7_done_grant", 32'(grant),       32'h0);
    check("t7_done_wins",  32'(timeout_err), 32'h0);
    step();

    // Randomised traffic. The per-transaction delays include both watchdog boundaries.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      if (m_owner >= 0 && m_gedge != plan_edge) begin
        plan_edge = m_gedge;
        case ($urandom_range(0, 7))
          0:       start_dly = 40;
          1:       start_dly = ST - 1;
          default: start_dly = $urandom_range(0, 6);
        endcase
        case ($urandom_range(0, 9))
          0:       done_dly = 200;
          1:       done_dly = TT - 1;
          default: done_dly = $urandom_range(0, 20);
        endcase
      end
      if (m_owner >= 0 && m_started == 0) tx_start = (m_cyc - m_gedge >= start_dly);
      else                                tx_start = ($urandom_range(0, 7) == 0);
      if (m_owner >= 0 && m_started != 0) tx_done = (m_cyc - m_t0 >= done_dly);
      else                                tx_done = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i])                            req[i] = ($urandom_range(0, 3) == 0);
        else if (m_owner == i && m_started == 0) req[i] = ($urandom_range(0, 23) != 0);
        else if (m_owner < 0 && m_last == i)     req[i] = ($urandom_range(0, 1) != 0);
        else if (m_owner != i)                   req[i] = ($urandom_range(0, 31) != 0);
      end
      step();
    end
    rst = 1'b0;
    tx_start = 1'b0;
    tx_done = 1'b0;
    req = '0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
